// File: rtl/fbf_pkg.sv
// rtl/fbf_pkg.sv - shared widths, state encoding and element packing for fbf_mult_driver
package fbf_pkg;

  localparam int MAT_DIM = 4;
  localparam int WORD_W  = 32;
  localparam int MAT_W   = 512;

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_STROBE,
    S_WAIT_RESULT,
    S_ACK,
    S_DRAIN
  } state_t;

  // Bit offset of element (m,n) is (4*m+n)*32, i.e. {m,n} followed by five zeros.
  function automatic logic [8:0] elem_off(input logic [1:0] m, input logic [1:0] n);
    return {m, n, 5'b00000};
  endfunction

endpackage

// File: rtl/fbf_word_serializer.sv
// rtl/fbf_word_serializer.sv - holds the product matrix and streams it out as 16 row-major words
module fbf_word_serializer
  import fbf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic [MAT_W-1:0]  data,
  input  logic              load,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              done
);

  logic [MAT_W-1:0] latch;
  logic [3:0]       k;
  logic [3:0]       k_next;

  assign k_next = k + 4'd1;
  assign done   = out_valid & out_ready & (k == 4'd15);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latch <= '0;
    end else if (capture) begin
      latch <= data;
    end
  end

  // out_data is preloaded with the next word so it is stable across any stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      k         <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= latch[elem_off(2'd0, 2'd0) +: WORD_W];
      out_last  <= 1'b0;
      k         <= '0;
    end else if (out_valid && out_ready) begin
      if (k == 4'd15) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        k         <= '0;
      end else begin
        k        <= k_next;
        out_data <= latch[elem_off(k_next[3:2], k_next[1:0]) +: WORD_W];
        out_last <= (k_next == 4'd15);
      end
    end
  end

endmodule

// File: rtl/fbf_mult_driver.sv
// rtl/fbf_mult_driver.sv - sequencer feeding the 4x4 matrix multiplier; FBF_TIMEOUT_EN adds a result-wait abort
module fbf_mult_driver
  import fbf_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic [MAT_W-1:0]  A,
  output logic [MAT_W-1:0]  B,
  output logic              A_stb,
  output logic              B_stb,
  input  logic [MAT_W-1:0]  result,
  input  logic              result_ready,
  output logic              result_ack,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              error
);

  state_t     state;
  logic [3:0] idx;
  logic       load;
  logic       capture;
  logic       done;
  logic       timeout;

  assign in_ready = (state == S_LOAD_A) || (state == S_LOAD_B);
  assign capture  = (state == S_WAIT_RESULT) && result_ready;

`ifdef FBF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  assign timeout = (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt  <= '0;
      error <= 1'b0;
    end else begin
      tcnt <= (state == S_WAIT_RESULT) ? tcnt + 1'b1 : '0;
      if ((state == S_WAIT_RESULT) && !result_ready && timeout) begin
        error <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_LOAD_A;
      idx        <= '0;
      A          <= '0;
      B          <= '0;
      A_stb      <= 1'b0;
      B_stb      <= 1'b0;
      result_ack <= 1'b0;
      load       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      A_stb <= 1'b0;
      B_stb <= 1'b0;
      load  <= 1'b0;
      case (state)
        S_LOAD_A: begin
          if (in_valid) begin
            A[elem_off(idx[3:2], idx[1:0]) +: WORD_W] <= in_data;
            idx  <= idx + 4'd1;
            busy <= 1'b1;
            if (idx == 4'd15) state <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (in_valid) begin
            B[elem_off(idx[3:2], idx[1:0]) +: WORD_W] <= in_data;
            idx <= idx + 4'd1;
            if (idx == 4'd15) begin
              state <= S_STROBE;
              A_stb <= 1'b1;
              B_stb <= 1'b1;
            end
          end
        end
        S_STROBE: begin
          state <= S_WAIT_RESULT;
        end
        S_WAIT_RESULT: begin
          if (result_ready) begin
            state      <= S_ACK;
            result_ack <= 1'b1;
          end else if (timeout) begin
            state <= S_LOAD_A;
            idx   <= '0;
            busy  <= 1'b0;
          end
        end
        S_ACK: begin
          if (!result_ready) begin
            state      <= S_DRAIN;
            result_ack <= 1'b0;
            load       <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (done) begin
            state <= S_LOAD_A;
            idx   <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_LOAD_A;
          idx   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  fbf_word_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .data      (result),
    .load      (load),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done)
  );

endmodule

// File: tb/tb_fbf_mult_driver.sv
// tb/tb_fbf_mult_driver.sv - randomized self-checking bench for fbf_mult_driver with a matrix-level model
module tb_fbf_mult_driver;

`ifdef FBF_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic [511:0] A;
  logic [511:0] B;
  logic         A_stb;
  logic         B_stb;
  logic [511:0] result;
  logic         result_ready;
  logic         result_ack;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_last;
  logic         out_ready;
  logic         busy;
  logic         error;

  fbf_mult_driver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .A            (A),
    .B            (B),
    .A_stb        (A_stb),
    .B_stb        (B_stb),
    .result       (result),
    .result_ready (result_ready),
    .result_ack   (result_ack),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .busy         (busy),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] ma [16];
  logic [31:0] mb [16];
  logic [31:0] mr [16];

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Element (m,n) of a row-major word list lands at bits ((4*m+n)*32)+:32.
  function automatic logic [511:0] pack(input logic [31:0] w [16]);
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = w[i];
    return v;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      ma[i] = $urandom;
      mb[i] = $urandom;
      mr[i] = $urandom;
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 1'b1);
    check_eq({tag, "_A"}, A, '0);
    check_eq({tag, "_B"}, B, '0);
    check_eq({tag, "_stb"}, {A_stb, B_stb}, 2'b00);
    check_eq({tag, "_ack"}, result_ack, 1'b0);
    check_eq({tag, "_out_valid"}, out_valid, 1'b0);
    check_eq({tag, "_out_data"}, out_data, 32'h0);
    check_eq({tag, "_out_last"}, out_last, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_error"}, error, 1'b0);
  endtask

  task automatic load_job(input bit gaps);
    for (int i = 0; i < 32; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 1'b0;
          step();
        end
      end
      in_valid = 1'b1;
      in_data  = (i < 16) ? ma[i] : mb[i-16];
      if (i == 0 || i == 16) check_eq("load_in_ready", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    check_eq("strobe_high", {A_stb, B_stb}, 2'b11);
    check_eq("A_matrix", A, pack(ma));
    check_eq("B_matrix", B, pack(mb));
    check_eq("strobe_in_ready", in_ready, 1'b0);
    check_eq("strobe_busy", busy, 1'b1);
    step();
    check_eq("strobe_one_cycle", {A_stb, B_stb}, 2'b00);
  endtask

  // omode: 0 full rate, 1 alternate on/off, 2 random; junk drives in_valid during the drain.
  task automatic finish_job(input int omode, input bit junk);
    int          got;
    int          cyc;
    bit          prev_stall;
    logic [31:0] prev_d;
    logic        prev_l;
    out_ready = 1'b0;
    repeat (19) step();
    check_eq("ack_before_ready", result_ack, 1'b0);
    result_ready = 1'b1;
    result       = pack(mr);
    step();
    check_eq("ack_rise", result_ack, 1'b1);
    step();
    check_eq("ack_held", result_ack, 1'b1);
    result_ready = 1'b0;
    result       = ~pack(mr);
    step();
    check_eq("ack_fall", result_ack, 1'b0);
    check_eq("valid_after_ack_fall", out_valid, 1'b0);
    step();
    check_eq("valid_rise", out_valid, 1'b1);
    got        = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_l     = 1'b0;
    while (got < 16 && cyc < 200) begin
      case (omode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 2) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (junk) begin
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        if (cyc == 0) check_eq("drain_in_ready", in_ready, 1'b0);
      end
      if (prev_stall) begin
        check_eq("stall_data", out_data, prev_d);
        check_eq("stall_last", out_last, prev_l);
      end
      if (out_valid) begin
        if (out_ready) begin
          check_eq("out_word", out_data, mr[got]);
          check_eq("out_last", out_last, (got == 15));
          got++;
        end
        prev_stall = !out_ready;
        prev_d     = out_data;
        prev_l     = out_last;
      end else begin
        prev_stall = 1'b0;
      end
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("drain_count", got, 16);
    if (omode == 0) check_eq("drain_cycles", cyc, 16);
    check_eq("done_busy", busy, 1'b0);
    check_eq("done_in_ready", in_ready, 1'b1);
    check_eq("done_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    reset        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    result       = '0;
    result_ready = 1'b0;
    out_ready    = 1'b0;
    repeat (3) step();
    check_idle("reset");
    reset = 1'b1;
    step();
    check_idle("post_reset");

    for (int i = 0; i < 16; i++) begin
      ma[i] = 32'h1 + i;
      mb[i] = 32'h101 + i;
      mr[i] = 32'hC0000000 + i;
    end
    load_job(1'b0);
    check_eq("A_first", A[31:0], 32'h1);
    check_eq("A_last", A[511:480], 32'h10);
    check_eq("B_first", B[31:0], 32'h101);
    finish_job(0, 1'b0);

    load_job(1'b1);
    finish_job(1, 1'b1);

    fill_random();
    load_job(1'b1);
    check_eq("A0_after_junk", A[31:0], ma[0]);
    finish_job(2, 1'b0);

    fill_random();
    load_job(1'b1);
    repeat (5) step();
    reset = 1'b0;
    step();
    check_idle("mid_reset");
    reset = 1'b1;
    step();
    fill_random();
    load_job(1'b0);
    finish_job(2, 1'b0);

`ifdef FBF_TIMEOUT_EN
    begin
      int n;
      bit ack_seen;
      fill_random();
      load_job(1'b0);
      n        = 0;
      ack_seen = 1'b0;
      while (!error && n < 50) begin
        step();
        ack_seen = ack_seen | result_ack;
        n++;
      end
      check_eq("timeout_cycles", n, 8);
      check_eq("timeout_error", error, 1'b1);
      check_eq("timeout_no_ack", ack_seen, 1'b0);
      check_eq("timeout_in_ready", in_ready, 1'b1);
      check_eq("timeout_busy", busy, 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fbf_mult_driver.md
# fbf_mult_driver

Initiator-side sequencer for the 4x4 single-precision matrix multiplier's strobe/ready/ack protocol. It takes a word-serial 32-bit stream, assembles matrices A and B, and strobes them into the multiplier. It then collects the 512-bit result, acknowledges it, and streams it back out word-serially. It sits between the host-side word bus and the multiplier, and drives every multiplier control input.

## Interface
- TIMEOUT_CYCLES, 1024, maximum S_WAIT_RESULT dwell before abort (used only with FBF_TIMEOUT_EN).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_data  in  32  input word (IEEE-754 single).
- in_ready  out  1  input word accepted when in_valid & in_ready.
- A, B  out  512 each  operand matrices; element (m,n) at bits ((4*m+n)*32)+:32.
- A_stb, B_stb  out  1 each  operand strobes, always driven identically.
- result  in  512  product matrix, same element packing as A and B.
- result_ready  in  1  product valid.
- result_ack  out  1  product consumed.
- out_valid  out  1  output word valid.
- out_data  out  32  output word.
- out_last  out  1  marks the 16th output word.
- out_ready  in  1  downstream accepts the output word.
- busy  out  1  high in any state other than S_LOAD_A with load index 0.
- error  out  1  sticky timeout flag; constant 0 without FBF_TIMEOUT_EN.

## Operation
- States:
  - S_LOAD_A (reset state)
  - S_LOAD_B
  - S_STROBE
  - S_WAIT_RESULT
  - S_ACK
  - S_DRAIN
- Load index: 4-bit, counts accepted beats within the current matrix.
- Loading:
  - in_ready is 1 in S_LOAD_A and S_LOAD_B, and 0 elsewhere.
  - Each accepted beat writes element (idx/4, idx%4), in row-major order: 16 beats for A, then 16 beats for B.
  - When the 16th A beat is accepted, the block moves to S_LOAD_B.
  - When the 16th B beat is accepted, the block moves to S_STROBE.
- S_STROBE:
  - A_stb = B_stb = 1 for exactly this one cycle.
  - Next state is S_WAIT_RESULT.
  - A and B are held stable from S_STROBE until result_ack is asserted.
- S_WAIT_RESULT: when result_ready = 1, the block latches result into an internal 512-bit register and moves to S_ACK.
- S_ACK:
  - result_ack = 1, held until result_ready is sampled 0.
  - Then result_ack = 0 and the block moves to S_DRAIN.
- S_DRAIN:
  - out_valid = 1 and out_data = latched element (k/4, k%4), where k is a 4-bit drain index.
  - k advances only on out_valid & out_ready.
  - out_last = 1 while k = 15.
  - When word 15 is accepted, the block returns to S_LOAD_A with both indices cleared.
- Boundary rules:
  - in_valid outside the load states is ignored; no beat is consumed.
  - result_ready outside S_WAIT_RESULT and S_ACK is ignored.
  - out_ready = 0 stalls S_DRAIN indefinitely; out_data and out_last stay stable.
  - Asserting reset mid-job abandons the job. The multiplier shares the same reset, so both sides return to idle together.
- Data is pass-through only: the block performs no arithmetic and does not interpret the float values.

## Timing
- All outputs are registered except in_ready, which decodes from state.
- Reset values:
  - state S_LOAD_A, both indices 0.
  - in_ready 1.
  - A and B 0; A_stb and B_stb 0.
  - result_ack 0.
  - out_valid, out_data and out_last 0.
  - busy 0, error 0.
- Minimum job duration is 32 input beats, then:
  - A_stb is asserted in the cycle after the 32nd beat is accepted.
  - result_ack is asserted in the cycle after result_ready is first sampled high.
  - out_valid is asserted one cycle after result_ack falls.
  - Draining takes 16 cycles at full out_ready.
- Throughput: one input beat per cycle and one output beat per cycle; loading does not overlap draining.

## Configuration
- FBF_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in S_WAIT_RESULT.
  - On reaching TIMEOUT_CYCLES, error is set to 1 (sticky until reset) and the block returns to S_LOAD_A with indices cleared.
  - result_ack is never asserted for an aborted job.
- FBF_TIMEOUT_EN undefined: there is no counter, error is tied to 0, and S_WAIT_RESULT waits forever.

## Structure
- Package fbf_pkg holds:
  - MAT_DIM = 4, WORD_W = 32, MAT_W = 512.
  - The state enum.
  - The element-offset function (4*m+n)*32.
- Sub-module fbf_word_serializer contains the 512-bit latch, the drain index and the out_valid/out_ready/out_last logic. It is started by a one-cycle load pulse and returns a done pulse.

## Test plan
- Stream A = 0x00000001..0x00000010 and B = 0x00000101..0x00000110 at full rate:
  - A[31:0] = 0x1, A[511:480] = 0x10, B[31:0] = 0x101.
  - A_stb = B_stb = 1 for exactly one cycle, in the cycle after beat 32.
- Responder model raises result_ready 20 cycles after the strobe, with word i = 0xC0000000+i and drops it 1 cycle after seeing ack:
  - result_ack rises 1 cycle after result_ready and falls after result_ready falls.
  - Output stream is 0xC0000000..0xC000000F, with out_last only on 0xC000000F.
- Apply in_valid with random gaps and out_ready toggling 1-on/1-off:
  - Same A, B and output word order as the first two scenarios.
  - out_data is stable during every stall.
- Pulse reset during S_WAIT_RESULT, then run a full job:
  - All outputs return to reset values, and in_ready = 1.
  - The next job completes correctly.
- Drive in_valid = 1 during S_DRAIN: in_ready = 0 and no beat is consumed. The next job's A[31:0] equals the first word sent after the drain.
- With FBF_TIMEOUT_EN and TIMEOUT_CYCLES = 8, hold result_ready at 0:
  - error = 1 after 8 wait cycles.
  - The block returns to S_LOAD_A, and result_ack never rises.
